inst_mem_sequencer: RTL and testbench

- Owns the single-port instruction RAM in the stack system and sequences all access to it.
- Runs in two phases:
  - LOAD: streams program words into the RAM from an external loader, with auto-incrementing addresses.
  - RUN: answers stack_cpu fetch requests (inst_complete / pc_next) with a fixed-latency RAM read and a one-cycle inst_ready pulse.
- Replaces the task-based load/fetch procedure in the system top with synthesizable RTL.

---
 rtl/stack_sys_pkg.sv | 17 +
 rtl/inst_mem_sequencer.sv | 147 ++++++++++++++
 tb/tb_inst_mem_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sys_pkg.sv
// Shared definitions for the stack system: CPU word width, the NOP encoding
// and the instruction-memory sequencer state encodings.
package stack_sys_pkg;

    localparam int CPU_BIT_WIDTH = 32;

    localparam logic [CPU_BIT_WIDTH-1:0] NOP_INST = '0;

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_IDLE = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_COOL = 3'd4
    } seq_state_e;

endpackage

// File: rtl/inst_mem_sequencer.sv
// Sole owner of the single-port instruction RAM: streams a program in during
// LOAD, then serves fixed-latency CPU fetches with a one-cycle ready pulse.
module inst_mem_sequencer
    import stack_sys_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_BIT_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  load_done,
    input  logic                  reload,
    input  logic                  cpu_inst_complete,
    input  logic [ADDR_WIDTH-1:0] cpu_pc_next,
    output logic [DATA_WIDTH-1:0] cpu_inst,
    output logic                  cpu_inst_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH-1:0] loaded_count,
    output logic                  fetch_fault
);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] loaded_count_q, loaded_count_d;
    logic                  fetch_fault_q, fetch_fault_d;
    logic                  fault_pend_q, fault_pend_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic [DATA_WIDTH-1:0] cpu_inst_q, cpu_inst_d;
    logic                  cpu_inst_ready_q, cpu_inst_ready_d;
    logic                  load_ready_q, load_ready_d;

    // NOTE: every register uses non-blocking assignment so all state updates
    // see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_LOAD;
            loaded_count_q   <= '0;
            fetch_fault_q    <= 1'b0;
            fault_pend_q     <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_addr_q       <= '0;
            ram_din_q        <= '0;
            cpu_inst_q       <= '0;
            cpu_inst_ready_q <= 1'b0;
            load_ready_q     <= 1'b1;
        end else begin
            state_q          <= state_d;
            loaded_count_q   <= loaded_count_d;
            fetch_fault_q    <= fetch_fault_d;
            fault_pend_q     <= fault_pend_d;
            ram_we_q         <= ram_we_d;
            ram_addr_q       <= ram_addr_d;
            ram_din_q        <= ram_din_d;
            cpu_inst_q       <= cpu_inst_d;
            cpu_inst_ready_q <= cpu_inst_ready_d;
            load_ready_q     <= load_ready_d;
        end
    end

    // NOTE: every next-state signal gets a default before the case statement,
    // so no path through the block can infer a latch.
    always_comb begin
        state_d          = state_q;
        loaded_count_d   = loaded_count_q;
        fetch_fault_d    = fetch_fault_q;
        fault_pend_d     = fault_pend_q;
        ram_we_d         = 1'b0;
        ram_addr_d       = ram_addr_q;
        ram_din_d        = ram_din_q;
        cpu_inst_d       = cpu_inst_q;
        cpu_inst_ready_d = 1'b0;
        load_ready_d     = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                load_ready_d = 1'b1;
                // A saturated counter has no address left, so the word is dropped.
                if (load_valid && (loaded_count_q != '1)) begin
                    ram_we_d       = 1'b1;
                    ram_addr_d     = loaded_count_q;
                    ram_din_d      = load_data;
                    loaded_count_d = loaded_count_q + ADDR_WIDTH'(1);
                end
                if (load_done) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (reload) begin
                    state_d        = S_LOAD;
                    loaded_count_d = '0;
                end else if (cpu_inst_complete) begin
                    ram_addr_d   = cpu_pc_next;
                    fault_pend_d = (cpu_pc_next >= loaded_count_q);
                    state_d      = S_RD1;
                end
            end

            S_RD1: begin
                state_d = S_RD2;
            end

            S_RD2: begin
                if (fault_pend_q) begin
                    cpu_inst_d    = DATA_WIDTH'(NOP_INST);
                    fetch_fault_d = 1'b1;
                end else begin
                    cpu_inst_d = ram_dout;
                end
                cpu_inst_ready_d = 1'b1;
                state_d          = S_COOL;
            end

            S_COOL: begin
                // The CPU is still dropping complete here, so it is not sampled.
                if (reload) begin
                    state_d        = S_LOAD;
                    loaded_count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign load_ready     = load_ready_q;
    assign cpu_inst       = cpu_inst_q;
    assign cpu_inst_ready = cpu_inst_ready_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_din        = ram_din_q;
    assign loaded_count   = loaded_count_q;
    assign fetch_fault    = fetch_fault_q;

endmodule

// File: tb/tb_inst_mem_sequencer.sv
// Self-checking bench for inst_mem_sequencer: a small synchronous RAM around
// the DUT plus a program/fault reference model kept as plain arrays.
module tb_inst_mem_sequencer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          load_done;
    logic          reload;
    logic          cpu_inst_complete;
    logic [AW-1:0] cpu_pc_next;
    logic [DW-1:0] cpu_inst;
    logic          cpu_inst_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] loaded_count;
    logic          fetch_fault;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    int            exp_count;
    bit            exp_fault;

    int tests_run    = 0;
    int tests_failed = 0;

    inst_mem_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .load_valid        (load_valid),
        .load_data         (load_data),
        .load_ready        (load_ready),
        .load_done         (load_done),
        .reload            (reload),
        .cpu_inst_complete (cpu_inst_complete),
        .cpu_pc_next       (cpu_pc_next),
        .cpu_inst          (cpu_inst),
        .cpu_inst_ready    (cpu_inst_ready),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout),
        .loaded_count      (loaded_count),
        .fetch_fault       (fetch_fault)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: registered read, one cycle after capture.
    always @(posedge clk) begin
        if (ram_we === 1'b1) ram[ram_addr[5:0]] <= ram_din;
        ram_dout <= ram[ram_addr[5:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid        = 1'b0;
        load_data         = '0;
        load_done         = 1'b0;
        reload            = 1'b0;
        cpu_inst_complete = 1'b0;
        cpu_pc_next       = '0;
    endtask

    task automatic load_word(input logic [DW-1:0] data, input logic done);
        load_valid = 1'b1;
        load_data  = data;
        load_done  = done;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        tests_run++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(exp_count) || ram_din !== data) begin
            tests_failed++;
            $display("FAIL load_write: we=%b addr=%0d din=%0d, expected we=1 addr=%0d din=%0d",
                     ram_we, ram_addr, ram_din, exp_count, data);
        end
        exp_mem[exp_count] = data;
        exp_count++;
        tests_run++;
        if (loaded_count !== AW'(exp_count)) begin
            tests_failed++;
            $display("FAIL load_count: got %0d expected %0d", loaded_count, exp_count);
        end
    endtask

    // Fetch from IDLE: complete sampled at edge S, delivery visible after S+2,
    // returns after S+3 with the sequencer back in IDLE.
    task automatic fetch(input logic [AW-1:0] pc, input string name);
        logic [DW-1:0] exp_inst;
        exp_inst          = (pc < AW'(exp_count)) ? exp_mem[pc[5:0]] : '0;
        cpu_inst_complete = 1'b1;
        cpu_pc_next       = pc;
        tick();
        cpu_inst_complete = 1'b0;
        cpu_pc_next       = $urandom;
        tick();
        tests_run++;
        if (cpu_inst_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s early_ready: got %b expected 0", name, cpu_inst_ready);
        end
        tick();
        if (pc >= AW'(exp_count)) exp_fault = 1'b1;
        tests_run++;
        if (cpu_inst_ready !== 1'b1 || cpu_inst !== exp_inst || fetch_fault !== exp_fault) begin
            tests_failed++;
            $display("FAIL %s deliver pc=%0d: ready=%b inst=%0d fault=%b, expected ready=1 inst=%0d fault=%b",
                     name, pc, cpu_inst_ready, cpu_inst, fetch_fault, exp_inst, exp_fault);
        end
        tick();
        tests_run++;
        if (cpu_inst_ready !== 1'b0 || cpu_inst !== exp_inst) begin
            tests_failed++;
            $display("FAIL %s hold: ready=%b inst=%0d, expected ready=0 inst=%0d",
                     name, cpu_inst_ready, cpu_inst, exp_inst);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        exp_count = 0;
        exp_fault = 1'b0;
        tests_run++;
        if ({ram_we, ram_addr, ram_din, cpu_inst, cpu_inst_ready, loaded_count, fetch_fault} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: we=%b addr=%0d din=%0d inst=%0d ready=%b count=%0d fault=%b, expected all 0",
                     ram_we, ram_addr, ram_din, cpu_inst, cpu_inst_ready, loaded_count, fetch_fault);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (load_ready !== 1'b1 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_load_ready: ready=%b we=%b, expected ready=1 we=0", load_ready, ram_we);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 30; i++) begin
            load_word((i == 5) ? DW'(1476395008) : DW'($urandom), 1'b0);
        end
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tests_run++;
        if (ram_we !== 1'b0 || load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_exit1: we=%b ready=%b, expected we=0 ready=1", ram_we, load_ready);
        end
        tick();
        tests_run++;
        if (load_ready !== 1'b0 || loaded_count !== 32'd30) begin
            tests_failed++;
            $display("FAIL load_exit2: ready=%b count=%0d, expected ready=0 count=30", load_ready, loaded_count);
        end
        for (int i = 0; i < 30; i++) begin
            tests_run++;
            if (ram[i] !== exp_mem[i]) begin
                tests_failed++;
                $display("FAIL ram_content[%0d]: got %0d expected %0d", i, ram[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_fetch_latency();
        fetch(32'd5, "fetch_word5");
        tests_run++;
        if (cpu_inst !== 32'd1476395008) begin
            tests_failed++;
            $display("FAIL word5_value: got %0d expected 1476395008", cpu_inst);
        end
    endtask

    task automatic test_held_complete();
        logic [AW-1:0] pc;
        logic [DW-1:0] exp_inst;
        logic          exp_ready;
        pc                = AW'($urandom_range(0, 29));
        exp_inst          = exp_mem[pc[5:0]];
        cpu_inst_complete = 1'b1;
        cpu_pc_next       = pc;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) cpu_inst_complete = 1'b0;
            exp_ready = (k == 2) || (k == 6);
            tests_run++;
            if (cpu_inst_ready !== exp_ready || (exp_ready && cpu_inst !== exp_inst)) begin
                tests_failed++;
                $display("FAIL held_complete cycle %0d: ready=%b inst=%0d, expected ready=%b inst=%0d",
                         k, cpu_inst_ready, cpu_inst, exp_ready, exp_inst);
            end
        end
    endtask

    task automatic test_fault();
        fetch(32'd30, "fault_fetch");
        fetch(AW'($urandom_range(0, 29)), "after_fault_fetch");
        tests_run++;
        if (fetch_fault !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_sticky: got %b expected 1", fetch_fault);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            fetch(AW'($urandom_range(0, 35)), "random_fetch");
        end
    endtask

    task automatic test_reload_and_reset();
        reload            = 1'b1;
        cpu_inst_complete = 1'b1;
        cpu_pc_next       = 32'd3;
        tick();
        reload            = 1'b0;
        cpu_inst_complete = 1'b0;
        exp_count         = 0;
        tests_run++;
        if (loaded_count !== 32'd0 || cpu_inst_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_count: count=%0d ready=%b, expected count=0 ready=0", loaded_count, cpu_inst_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (cpu_inst_ready !== 1'b0 || load_ready !== 1'b1 || fetch_fault !== exp_fault) begin
                tests_failed++;
                $display("FAIL reload_state cycle %0d: ready=%b load_ready=%b fault=%b, expected 0 1 %b",
                         k, cpu_inst_ready, load_ready, fetch_fault, exp_fault);
            end
        end
        load_word($urandom, 1'b0);
        load_valid = 1'b1;
        load_data  = $urandom;
        rst        = 1'b1;
        tick();
        load_valid = 1'b0;
        rst        = 1'b0;
        exp_count  = 0;
        exp_fault  = 1'b0;
        tests_run++;
        if ({ram_we, ram_addr, ram_din, cpu_inst, cpu_inst_ready, loaded_count, fetch_fault} !== '0
            || load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midload_reset: we=%b addr=%0d din=%0d inst=%0d ready=%b count=%0d fault=%b load_ready=%b",
                     ram_we, ram_addr, ram_din, cpu_inst, cpu_inst_ready, loaded_count, fetch_fault, load_ready);
        end
    endtask

    task automatic test_done_same_cycle();
        cpu_inst_complete = 1'b1;
        cpu_pc_next       = '0;
        tick();
        cpu_inst_complete = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (cpu_inst_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL complete_in_load cycle %0d: ready=%b expected 0", k, cpu_inst_ready);
            end
        end
        for (int i = 0; i < 3; i++) load_word($urandom, 1'b0);
        load_word(32'd805306368, 1'b1);
        tick();
        tests_run++;
        if (ram_we !== 1'b0 || loaded_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL done_with_valid: we=%b count=%0d, expected we=0 count=4", ram_we, loaded_count);
        end
        fetch(32'd3, "fetch_last_word");
        tests_run++;
        if (cpu_inst !== 32'd805306368 || fetch_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_word_value: inst=%0d fault=%b, expected 805306368 0", cpu_inst, fetch_fault);
        end
        fetch(32'd4, "fetch_past_end");
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch_latency();
        test_held_complete();
        test_fault();
        test_back_to_back();
        test_reload_and_reset();
        test_done_same_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
